// File: rtl/airi5c_custom_bitmanip.sv
// PCPI bit-manipulation coprocessor (custom opcode 7'h77, funct7 7'h20).
// Ops by funct3: REV, BSWAP, CPOP, CLZ, CTZ and, with AIRI5C_CUSTOM_ROT_EN
// defined, ROL/ROR. The counting ops consume BITS_PER_CYCLE bits per cycle.
// Optional feature macro: AIRI5C_CUSTOM_ROT_EN (rotator present, funct3 5/6 decode).
module airi5c_custom_bitmanip #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned BITS_PER_CYCLE = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pcpi_valid,
    input  logic [XLEN-1:0] pcpi_insn,
    input  logic [XLEN-1:0] pcpi_rs1,
    input  logic [XLEN-1:0] pcpi_rs2,
    input  logic [XLEN-1:0] pcpi_rs3,
    output logic            pcpi_wr,
    output logic [XLEN-1:0] pcpi_rd,
    output logic [XLEN-1:0] pcpi_rd2,
    output logic            pcpi_use_rd64,
    output logic            pcpi_wait,
    output logic            pcpi_ready
);

    localparam int unsigned NSLICE  = XLEN / BITS_PER_CYCLE;
    localparam int unsigned CNT_W   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int unsigned SHAMT_W = $clog2(XLEN);

    localparam logic [2:0] F3_REV   = 3'd0;
    localparam logic [2:0] F3_BSWAP = 3'd1;
    localparam logic [2:0] F3_CPOP  = 3'd2;
    localparam logic [2:0] F3_CLZ   = 3'd3;
    localparam logic [2:0] F3_CTZ   = 3'd4;
    localparam logic [2:0] F3_ROL   = 3'd5;
    localparam logic [2:0] F3_ROR   = 3'd6;

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_t;

    state_t             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [XLEN-1:0]    rs1_q, rs1_d;
    logic [SHAMT_W-1:0] amt_q, amt_d;
    logic [XLEN-1:0]    result_q, result_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               seen_q, seen_d;

    // Instruction fields live in the low 32 bits regardless of XLEN.
    logic [31:0] insn32;
    logic        legal_f3, dec_hit, accept, is_count;
    assign insn32 = 32'(pcpi_insn);

    // Unused operand bits are tied into a dead reduction.
    logic unused_inputs;
    assign unused_inputs = ^{pcpi_rs3, pcpi_insn, pcpi_rs2, insn32};

    // Decode: legal funct3 set depends on whether the rotator is built.
    always_comb begin
        legal_f3 = 1'b0;
        case (insn32[14:12])
            F3_REV, F3_BSWAP, F3_CPOP, F3_CLZ, F3_CTZ: legal_f3 = 1'b1;
`ifdef AIRI5C_CUSTOM_ROT_EN
            F3_ROL, F3_ROR: legal_f3 = 1'b1;
`endif
            default: legal_f3 = 1'b0;
        endcase
    end

    assign dec_hit  = (insn32[6:0] == 7'h77) && (insn32[31:25] == 7'h20) && legal_f3;
    assign accept   = pcpi_valid && dec_hit;
    assign is_count = (insn32[14:12] == F3_CPOP) || (insn32[14:12] == F3_CLZ) ||
                      (insn32[14:12] == F3_CTZ);

    // Single-cycle datapath results and per-slice counting terms.
    logic [XLEN-1:0]           rev_res, bswap_res, rol_res, ror_res;
    logic [XLEN-1:0]           slice_pop, slice_tz, slice_lz;
    logic [BITS_PER_CYCLE-1:0] slice_lo, slice_hi;

    always_comb begin
        rev_res   = '0;
        bswap_res = '0;
        slice_pop = '0;
        slice_lo  = rs1_q[BITS_PER_CYCLE-1:0];
        slice_hi  = rs1_q[XLEN-1 -: BITS_PER_CYCLE];
        slice_tz  = XLEN'(BITS_PER_CYCLE);
        slice_lz  = XLEN'(BITS_PER_CYCLE);
        for (int i = 0; i < int'(XLEN); i++) begin
            rev_res[i] = rs1_q[int'(XLEN) - 1 - i];
        end
        for (int b = 0; b < int'(XLEN / 8); b++) begin
            bswap_res[8*b +: 8] = rs1_q[int'(XLEN) - 8 - 8*b +: 8];
        end
        for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
            slice_pop = slice_pop + XLEN'(slice_lo[i]);
        end
        // Lowest set bit wins for CTZ, highest set bit wins for CLZ.
        for (int i = int'(BITS_PER_CYCLE) - 1; i >= 0; i--) begin
            if (slice_lo[i]) slice_tz = XLEN'(i);
        end
        for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
            if (slice_hi[i]) slice_lz = XLEN'(int'(BITS_PER_CYCLE) - 1 - i);
        end
    end

`ifdef AIRI5C_CUSTOM_ROT_EN
    // Rotator; a shift by XLEN yields 0, so amount 0 returns rs1 unchanged.
    logic [31:0] amt32;
    always_comb begin
        amt32   = 32'(amt_q);
        rol_res = (rs1_q << amt32) | (rs1_q >> (32'(XLEN) - amt32));
        ror_res = (rs1_q >> amt32) | (rs1_q << (32'(XLEN) - amt32));
    end
`else
    assign rol_res = '0;
    assign ror_res = '0;
`endif

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rs1_d    = rs1_q;
        amt_d    = amt_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        seen_d   = seen_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    op_d     = insn32[14:12];
                    rs1_d    = pcpi_rs1;
                    amt_d    = pcpi_rs2[SHAMT_W-1:0];
                    result_d = '0;
                    seen_d   = 1'b0;
                    cnt_d    = is_count ? CNT_W'(NSLICE - 1) : '0;
                    state_d  = StExec;
                end
            end
            StExec: begin
                if (!pcpi_valid) begin
                    state_d = StIdle;
                end else begin
                    case (op_q)
                        F3_REV:   begin result_d = rev_res;   state_d = StDone; end
                        F3_BSWAP: begin result_d = bswap_res; state_d = StDone; end
                        F3_ROL:   begin result_d = rol_res;   state_d = StDone; end
                        F3_ROR:   begin result_d = ror_res;   state_d = StDone; end
                        F3_CPOP, F3_CLZ, F3_CTZ: begin
                            if (op_q == F3_CPOP) begin
                                result_d = result_q + slice_pop;
                                rs1_d    = rs1_q >> BITS_PER_CYCLE;
                            end else if (op_q == F3_CTZ) begin
                                if (!seen_q) result_d = result_q + slice_tz;
                                seen_d = seen_q | (|slice_lo);
                                rs1_d  = rs1_q >> BITS_PER_CYCLE;
                            end else begin
                                if (!seen_q) result_d = result_q + slice_lz;
                                seen_d = seen_q | (|slice_hi);
                                rs1_d  = rs1_q << BITS_PER_CYCLE;
                            end
                            if (cnt_q == '0) state_d = StDone;
                            else             cnt_d   = cnt_q - CNT_W'(1);
                        end
                        default: state_d = StIdle;
                    endcase
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            op_q     <= '0;
            rs1_q    <= '0;
            amt_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            seen_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rs1_q    <= rs1_d;
            amt_q    <= amt_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            seen_q   <= seen_d;
        end
    end

    // PCPI outputs; wait is gated by reset so a held valid is never claimed.
    always_comb begin
        pcpi_ready    = (state_q == StDone);
        pcpi_wr       = pcpi_ready;
        pcpi_rd       = pcpi_ready ? result_q : '0;
        pcpi_rd2      = '0;
        pcpi_use_rd64 = 1'b0;
        pcpi_wait     = !reset && (((state_q == StIdle) && accept) || (state_q == StExec));
    end

endmodule

// File: tb/tb_airi5c_custom_bitmanip.sv
// Self-checking bench for airi5c_custom_bitmanip: table-driven ops with a
// result scoreboard, plus hand-written reset, abort and decode-miss sequences.
module tb_airi5c_custom_bitmanip;

    localparam int XLEN    = 32;
    localparam int BPC     = 8;
    localparam int CNT_LAT = XLEN / BPC + 1;
    localparam int BUDGET  = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic            pcpi_valid;
    logic [XLEN-1:0] pcpi_insn, pcpi_rs1, pcpi_rs2, pcpi_rs3;
    logic            pcpi_wr, pcpi_use_rd64, pcpi_wait, pcpi_ready;
    logic [XLEN-1:0] pcpi_rd, pcpi_rd2;

    always #5 clk = ~clk;

    airi5c_custom_bitmanip #(
        .XLEN           (XLEN),
        .BITS_PER_CYCLE (BPC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pcpi_valid    (pcpi_valid),
        .pcpi_insn     (pcpi_insn),
        .pcpi_rs1      (pcpi_rs1),
        .pcpi_rs2      (pcpi_rs2),
        .pcpi_rs3      (pcpi_rs3),
        .pcpi_wr       (pcpi_wr),
        .pcpi_rd       (pcpi_rd),
        .pcpi_rd2      (pcpi_rd2),
        .pcpi_use_rd64 (pcpi_use_rd64),
        .pcpi_wait     (pcpi_wait),
        .pcpi_ready    (pcpi_ready)
    );

    int checks = 0;
    int passed = 0;
    logic [31:0] sb_q[$];

    typedef struct {
        string       name;
        logic [31:0] insn;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] exp;
        int          lat;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3,
                                       input logic [6:0] opc);
        return {f7, 5'd2, 5'd1, f3, 5'd3, opc};
    endfunction

    // Issue one insn, hold valid until ready, score result and latency.
    task automatic run_op(input string name, input logic [31:0] insn, input logic [31:0] rs1,
                          input logic [31:0] rs2, input logic [31:0] exp, input int lat);
        logic quiet_ok;
        logic got;
        logic [31:0] want;
        @(negedge clk);
        pcpi_valid = 1'b1;
        pcpi_insn  = insn;
        pcpi_rs1   = rs1;
        pcpi_rs2   = rs2;
        sb_q.push_back(exp);
        #1 check({name, " wait@0"}, 64'(pcpi_wait), 64'(1));
        quiet_ok = 1'b1;
        got      = 1'b0;
        for (int k = 1; k <= BUDGET; k++) begin
            @(negedge clk);
            if (pcpi_ready) begin
                want = sb_q.pop_front();
                check({name, " latency"}, 64'(k), 64'(lat));
                check({name, " wr"}, 64'(pcpi_wr), 64'(1));
                check({name, " rd"}, 64'(pcpi_rd), 64'(want));
                got = 1'b1;
                break;
            end
            if (pcpi_rd !== '0 || pcpi_wait !== 1'b1 || pcpi_wr !== 1'b0) quiet_ok = 1'b0;
        end
        if (!got) begin
            check({name, " timeout"}, 64'(got), 64'(1));
            void'(sb_q.pop_front());
        end
        check({name, " pending outputs"}, 64'(quiet_ok), 64'(1));
        pcpi_valid = 1'b0;
    endtask

    // Present a non-matching insn for 16 cycles; wait/ready must stay low.
    task automatic run_miss(input string name, input logic [31:0] insn);
        logic bad;
        bad = 1'b0;
        @(negedge clk);
        pcpi_valid = 1'b1;
        pcpi_insn  = insn;
        pcpi_rs1   = 32'h8000_0001;
        pcpi_rs2   = 32'h0000_0021;
        for (int k = 0; k < 16; k++) begin
            #1 if (pcpi_wait !== 1'b0 || pcpi_ready !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        check({name, " miss quiet"}, 64'(bad), 64'(0));
        pcpi_valid = 1'b0;
    endtask

    initial begin
        logic spurious;

        vecs.push_back('{"REV 1",       mk(7'h20, 3'd0, 7'h77), 32'h0000_0001, 0, 32'h8000_0000, 2});
        vecs.push_back('{"REV A",       mk(7'h20, 3'd0, 7'h77), 32'hA000_0000, 0, 32'h0000_0005, 2});
        vecs.push_back('{"BSWAP",       mk(7'h20, 3'd1, 7'h77), 32'h1122_3344, 0, 32'h4433_2211, 2});
        vecs.push_back('{"CPOP",        mk(7'h20, 3'd2, 7'h77), 32'hF0F0_000F, 0, 32'd12, CNT_LAT});
        vecs.push_back('{"CPOP ones",   mk(7'h20, 3'd2, 7'h77), 32'hFFFF_FFFF, 0, 32'd32, CNT_LAT});
        vecs.push_back('{"CLZ",         mk(7'h20, 3'd3, 7'h77), 32'h0001_0000, 0, 32'd15, CNT_LAT});
        vecs.push_back('{"CLZ zero",    mk(7'h20, 3'd3, 7'h77), 32'h0000_0000, 0, 32'd32, CNT_LAT});
        vecs.push_back('{"CLZ ones",    mk(7'h20, 3'd3, 7'h77), 32'hFFFF_FFFF, 0, 32'd0,  CNT_LAT});
        vecs.push_back('{"CTZ zero",    mk(7'h20, 3'd4, 7'h77), 32'h0000_0000, 0, 32'd32, CNT_LAT});
        vecs.push_back('{"CTZ 0x100",   mk(7'h20, 3'd4, 7'h77), 32'h0000_0100, 0, 32'd8,  CNT_LAT});
        vecs.push_back('{"CTZ msb",     mk(7'h20, 3'd4, 7'h77), 32'h8000_0000, 0, 32'd31, CNT_LAT});
`ifdef AIRI5C_CUSTOM_ROT_EN
        vecs.push_back('{"ROL 1",  mk(7'h20, 3'd5, 7'h77), 32'h8000_0001, 32'h21, 32'h0000_0003, 2});
        vecs.push_back('{"ROR 1",  mk(7'h20, 3'd6, 7'h77), 32'h0000_0003, 32'h01, 32'h8000_0001, 2});
        vecs.push_back('{"ROL 0",  mk(7'h20, 3'd5, 7'h77), 32'h1234_5678, 32'h20, 32'h1234_5678, 2});
`endif

        // Reset held with a valid, matching insn presented.
        reset      = 1'b1;
        pcpi_valid = 1'b1;
        pcpi_insn  = mk(7'h20, 3'd0, 7'h77);
        pcpi_rs1   = 32'h1;
        pcpi_rs2   = '0;
        pcpi_rs3   = '0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("reset wait",  64'(pcpi_wait),  64'(0));
            check("reset ready", 64'(pcpi_ready), 64'(0));
            check("reset wr",    64'(pcpi_wr),    64'(0));
            check("reset rd",    64'(pcpi_rd),    64'(0));
        end
        check("rd2 const",   64'(pcpi_rd2),      64'(0));
        check("rd64 const",  64'(pcpi_use_rd64), 64'(0));
        reset      = 1'b0;
        pcpi_valid = 1'b0;

        foreach (vecs[i]) begin
            run_op(vecs[i].name, vecs[i].insn, vecs[i].rs1, vecs[i].rs2, vecs[i].exp, vecs[i].lat);
        end

        // Abort: CPOP at cycle 0, valid dropped at cycle 2, CLZ issued at cycle 4.
        @(negedge clk);
        pcpi_valid = 1'b1;
        pcpi_insn  = mk(7'h20, 3'd2, 7'h77);
        pcpi_rs1   = 32'hFFFF_FFFF;
        spurious   = 1'b0;
        @(negedge clk);
        if (pcpi_ready) spurious = 1'b1;
        @(negedge clk);
        if (pcpi_ready) spurious = 1'b1;
        pcpi_valid = 1'b0;
        @(negedge clk);
        if (pcpi_ready) spurious = 1'b1;
        check("abort idle wait", 64'(pcpi_wait), 64'(0));
        check("abort no ready",  64'(spurious),  64'(0));
        run_op("CLZ after abort", mk(7'h20, 3'd3, 7'h77), 32'h0000_00FF, 0, 32'd24, CNT_LAT);

        // Reset pulsed at cycle 3 of a CPOP: no completion may follow.
        @(negedge clk);
        pcpi_valid = 1'b1;
        pcpi_insn  = mk(7'h20, 3'd2, 7'h77);
        pcpi_rs1   = 32'h0F0F_0F0F;
        spurious   = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (pcpi_ready) spurious = 1'b1;
        end
        reset = 1'b1;
        @(negedge clk);
        reset      = 1'b0;
        pcpi_valid = 1'b0;
        #1 check("reset mid-op wait", 64'(pcpi_wait), 64'(0));
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (pcpi_ready || pcpi_wr) spurious = 1'b1;
        end
        check("reset mid-op no ready", 64'(spurious), 64'(0));
        run_op("CPOP after reset", mk(7'h20, 3'd2, 7'h77), 32'h0F0F_0F0F, 0, 32'd16, CNT_LAT);

        run_miss("SIMD funct7", mk(7'h54, 3'd0, 7'h77));
        run_miss("funct3 7",    mk(7'h20, 3'd7, 7'h77));
        run_miss("opcode 33",   mk(7'h20, 3'd0, 7'h33));
`ifndef AIRI5C_CUSTOM_ROT_EN
        run_miss("ROL disabled", mk(7'h20, 3'd5, 7'h77));
        run_miss("ROR disabled", mk(7'h20, 3'd6, 7'h77));
`endif

        check("scoreboard drained", 64'(sb_q.size()), 64'(0));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
